// File: rtl/mmio_pkg.sv
// Shared MMIO register map and status bit positions for mmio_bridge.
package mmio_pkg;

  // Register offsets within the 256-byte MMIO window
  localparam logic [7:0] OFF_OUT_DATA   = 8'h00;
  localparam logic [7:0] OFF_OUT_STATUS = 8'h04;
  localparam logic [7:0] OFF_IN_DATA    = 8'h08;
  localparam logic [7:0] OFF_IN_STATUS  = 8'h0C;
  localparam logic [7:0] OFF_CYCLE      = 8'h10;
  localparam logic [7:0] OFF_LED        = 8'h14;

  // OUT_STATUS bit positions
  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_OVF   = 2;

  // IN_STATUS bit positions
  localparam int unsigned ST_VLD = 0;
  localparam int unsigned ST_OVR = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes when full and pops when
// empty are ignored here, the caller owns any overflow bookkeeping.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards contents by equalising the pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU data-bus endpoint: routes accesses to data memory or the MMIO
// register file (TX FIFO, PDU input latch, cycle counter, LEDs).
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00,
  parameter int unsigned DM_AW      = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_addr,
  input  logic             mem_we,
  input  logic [31:0]      mem_din,
  output logic [31:0]      mem_dout,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic [LED_W-1:0] led
);

  logic        dm_hit;
  logic        mmio_hit;
  logic [7:0]  off;
  logic        wr_mmio;
  logic        wr_out_data;
  logic        wr_out_status;
  logic        wr_in_status;
  logic        wr_cycle;
  logic        wr_led;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        push_drop;
  logic        clr_vld;
  logic        clr_ovr;
  logic        ovf;
  logic        vld;
  logic        ovr;
  logic [31:0] in_word;
  logic [31:0] cycle;
  logic [31:0] mmio_rd;
  logic        unused_addr_lsb;

  assign dm_hit          = (mem_addr[31:DM_AW+2] == '0);
  assign mmio_hit        = (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign off             = {mem_addr[7:2], 2'b00};
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign dm_addr = mem_addr[DM_AW+1:2];
  assign dm_we   = mem_we & dm_hit;
  assign dm_din  = mem_din;

  assign wr_mmio       = mem_we & mmio_hit;
  assign wr_out_data   = wr_mmio && (off == OFF_OUT_DATA);
  assign wr_out_status = wr_mmio && (off == OFF_OUT_STATUS);
  assign wr_in_status  = wr_mmio && (off == OFF_IN_STATUS);
  assign wr_cycle      = wr_mmio && (off == OFF_CYCLE);
  assign wr_led        = wr_mmio && (off == OFF_LED);

  assign out_valid = ~fifo_empty;
  assign fifo_pop  = out_valid & out_ready;
  // full is pre-edge state, so a push is dropped even alongside a pop
  assign push_drop = wr_out_data & fifo_full;
  assign clr_vld   = wr_in_status & mem_din[ST_VLD];
  assign clr_ovr   = wr_in_status & mem_din[ST_OVR];

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_out_data),
    .pop  (fifo_pop),
    .din  (mem_din),
    .dout (out_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // TX overflow flag: sticky on dropped push, set beats CPU clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  ovf <= 1'b0;
    else if (push_drop)                        ovf <= 1'b1;
    else if (wr_out_status && mem_din[ST_OVF]) ovf <= 1'b0;
  end

  // PDU input latch with valid/overrun flags; a word consumed by a vld clear
  // in the same cycle as a new strobe does not count as an overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_word <= '0;
      vld     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (in_valid) in_word <= in_data;
      if (in_valid)     vld <= 1'b1;
      else if (clr_vld) vld <= 1'b0;
      ovr <= (ovr & ~clr_ovr) | (in_valid & vld & ~clr_vld);
    end
  end

  // Free-running cycle counter, zeroed by any write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cycle <= '0;
    else if (wr_cycle) cycle <= '0;
    else               cycle <= cycle + 32'd1;
  end

  // LED register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        led <= '0;
    else if (wr_led) led <= mem_din[LED_W-1:0];
  end

  // MMIO read mux, side-effect free
  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_OUT_STATUS: begin
        mmio_rd[ST_FULL]  = fifo_full;
        mmio_rd[ST_EMPTY] = fifo_empty;
        mmio_rd[ST_OVF]   = ovf;
      end
      OFF_IN_DATA: mmio_rd = in_word;
      OFF_IN_STATUS: begin
        mmio_rd[ST_VLD] = vld;
        mmio_rd[ST_OVR] = ovr;
      end
      OFF_CYCLE: mmio_rd = cycle;
      OFF_LED:   mmio_rd[LED_W-1:0] = led;
      default:   mmio_rd = '0;
    endcase
  end

  // CPU read data select
  always_comb begin
    mem_dout = '0;
    if (dm_hit)        mem_dout = dm_dout;
    else if (mmio_hit) mem_dout = mmio_rd;
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: CPU reads checked against expected
// values, TX FIFO output checked against a scoreboard queue.
module tb_mmio_bridge;

  localparam logic [31:0] A_OUT_DATA   = 32'h0000_7F00;
  localparam logic [31:0] A_OUT_STATUS = 32'h0000_7F04;
  localparam logic [31:0] A_IN_DATA    = 32'h0000_7F08;
  localparam logic [31:0] A_IN_STATUS  = 32'h0000_7F0C;
  localparam logic [31:0] A_CYCLE      = 32'h0000_7F10;
  localparam logic [31:0] A_LED        = 32'h0000_7F14;
  localparam logic [31:0] A_IDLE       = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = A_IDLE;
  logic        mem_we = 1'b0;
  logic [31:0] mem_din = '0;
  logic [31:0] mem_dout;
  logic [7:0]  dm_addr;
  logic        dm_we;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] led;

  logic [31:0] ram [256];
  logic [31:0] tx_q [$];
  logic [31:0] rd_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          pops = 0;
  int          pops_base;

  mmio_bridge #(
    .MMIO_BASE (32'h0000_7F00),
    .DM_AW     (8),
    .FIFO_DEPTH(8),
    .LED_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .dm_addr  (dm_addr),
    .dm_we    (dm_we),
    .dm_din   (dm_din),
    .dm_dout  (dm_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .in_data  (in_data),
    .in_valid (in_valid),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, clocked write
  assign dm_dout = ram[dm_addr];
  always @(posedge clk) if (dm_we) ram[dm_addr] <= dm_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // TX scoreboard: every accepted transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (tx_q.size() == 0) check("tx_extra_pop", 32'(tx_q.size()), 32'd1);
      else check("tx_data", out_data, tx_q.pop_front());
      pops++;
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_addr = a;
    mem_we   = we;
    mem_din  = d;
    in_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    drive(a, 1'b1, d);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    drive(a, 1'b0, '0);
    rd_q.push_back(exp);
    @(negedge clk);
    check(tag, mem_dout, rd_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(A_IDLE, 1'b0, '0);
      @(negedge clk);
    end
  endtask

  task automatic push_word(input logic [31:0] v, input bit accept);
    if (accept) tx_q.push_back(v);
    cpu_write(A_OUT_DATA, v);
  endtask

  task automatic pdu_in(input logic [31:0] d);
    drive(A_IDLE, 1'b0, '0);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and first-cycle reads
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b1;
    cpu_read(A_OUT_STATUS, 32'h2, "init_out_status");
    cpu_read(A_CYCLE, 32'd2, "init_cycle");

    // Data memory path and decode boundaries
    drive(32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("dm_we_store", 32'(dm_we), 32'd1);
    check("dm_addr_store", 32'(dm_addr), 32'h10);
    cpu_read(32'h0000_0040, 32'hDEAD_BEEF, "dm_load");
    cpu_write(32'h0000_0000, 32'h1111_1111);
    cpu_write(32'h0000_03FC, 32'h0000_0055);
    cpu_read(32'h0000_03FC, 32'h0000_0055, "dm_top_word");
    cpu_read(32'h0000_0400, 32'h0, "dm_above_top");
    drive(32'h0000_2000, 1'b1, 32'hCAFE_0000);
    @(negedge clk);
    check("unmapped_dm_we", 32'(dm_we), 32'd0);
    check("unmapped_read", mem_dout, 32'h0);

    // Fill FIFO past full, then drain
    for (int i = 1; i <= 9; i++) push_word(32'(i), i <= 8);
    cpu_read(A_OUT_STATUS, 32'h5, "full_ovf_status");
    cpu_read(A_OUT_DATA, 32'h0, "out_data_reads_zero");
    drive(A_IDLE, 1'b0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    idle(10);
    check("tx_drained", 32'(tx_q.size()), 32'd0);
    check("tx_valid_low", 32'(out_valid), 32'd0);
    cpu_read(A_OUT_STATUS, 32'h6, "empty_ovf_status");
    cpu_write(A_OUT_STATUS, 32'h4);
    cpu_read(A_OUT_STATUS, 32'h2, "ovf_cleared");

    // Full FIFO: pop and push in the same cycle drops the push
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i), 1'b1);
    pops_base = pops;
    drive(A_OUT_DATA, 1'b1, 32'h0000_00AA);
    out_ready = 1'b1;
    @(negedge clk);
    drive(A_OUT_STATUS, 1'b0, '0);
    out_ready = 1'b0;
    @(negedge clk);
    check("pushpop_full_status", mem_dout, 32'h4);
    drive(A_IDLE, 1'b0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    idle(10);
    check("pushpop_total_pops", 32'(pops - pops_base), 32'd8);
    check("pushpop_drained", 32'(tx_q.size()), 32'd0);
    out_ready = 1'b0;
    cpu_write(A_OUT_STATUS, 32'h4);

    // PDU input latch, overrun, and clear racing a new strobe
    pdu_in(32'h1234);
    pdu_in(32'h5678);
    cpu_read(A_IN_DATA, 32'h5678, "in_data_latest");
    cpu_read(A_IN_STATUS, 32'h3, "in_status_ovr");
    cpu_write(A_IN_DATA, 32'hFFFF_FFFF);
    cpu_read(A_IN_DATA, 32'h5678, "in_data_write_ignored");
    drive(A_IN_STATUS, 1'b1, 32'h3);
    in_valid = 1'b1;
    in_data  = 32'h9ABC;
    @(negedge clk);
    cpu_read(A_IN_STATUS, 32'h1, "in_clear_vs_set");
    cpu_read(A_IN_DATA, 32'h9ABC, "in_data_after_race");

    // LED and cycle counter
    cpu_write(A_LED, 32'hFFFF_FFFF);
    cpu_read(A_LED, 32'h0000_FFFF, "led_read");
    check("led_port", 32'(led), 32'h0000_FFFF);
    cpu_write(A_CYCLE, 32'h1234_5678);
    idle(4);
    cpu_read(A_CYCLE, 32'd4, "cycle_after_clear");
    cpu_read(32'h0000_7F20, 32'h0, "mmio_unused_offset");

    // Reset mid-operation
    for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i), 1'b1);
    cpu_write(A_LED, 32'h0000_1234);
    pdu_in(32'h77);
    idle(1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tx_q.delete();
    mem_addr = 32'h0000_0040;
    mem_we   = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_dm_passthru", mem_dout, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_read(A_CYCLE, 32'd1, "midrst_cycle");
    cpu_read(A_OUT_STATUS, 32'h2, "midrst_out_status");
    cpu_read(A_IN_STATUS, 32'h0, "midrst_in_status");
    cpu_read(A_IN_DATA, 32'h0, "midrst_in_data");
    cpu_read(A_LED, 32'h0, "midrst_led_read");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Data-bus endpoint sitting directly downstream of the single-cycle CPU core's mem_addr/mem_we/mem_din/mem_dout port. It decodes each access and routes it either to the data memory or to a small MMIO register file. The register file holds a TX FIFO toward the PDU, a latched input word from the PDU, an LED register and a free-running cycle counter. Reads are combinational, because the core completes loads in one cycle; all writes and state changes happen on the rising clock edge.

Parameters:
MMIO_BASE, 32'h0000_7F00, base address of the MMIO window (256 bytes)
DM_AW, 8, data memory word-address width; DM covers byte addresses 0 .. 4*2^DM_AW-1
FIFO_DEPTH, 8, TX FIFO entries, power of 2, at least 2
LED_W, 16, LED register width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
mem_addr  in  32  CPU byte address
mem_we  in  1  CPU store strobe
mem_din  in  32  CPU store data
mem_dout  out  32  read data to CPU, combinational
dm_addr  out  DM_AW  data memory word address (mem_addr[DM_AW+1:2])
dm_we  out  1  data memory write enable
dm_din  out  32  data memory write data (mem_din)
dm_dout  in  32  data memory read data, combinational
out_data  out  32  TX FIFO head toward PDU
out_valid  out  1  TX FIFO non-empty
out_ready  in  1  PDU accepts head
in_data  in  32  PDU input word
in_valid  in  1  one-cycle strobe: in_data is valid
led  out  LED_W  LED register

Behaviour:
- Decode:
  - DM hit: mem_addr < 4*2^DM_AW.
  - MMIO hit: mem_addr[31:8] == MMIO_BASE[31:8].
  - Any other address reads 32'h0 and ignores writes.
  - dm_we = mem_we & DM hit.
  - mem_dout = dm_dout on a DM hit, else the MMIO read value.
- MMIO map (offset = mem_addr[7:0]; mem_addr[1:0] ignored):
  - 0x00 OUT_DATA: W pushes mem_din into the FIFO. R returns 0.
  - 0x04 OUT_STATUS: R = {29'b0, ovf, empty, full}. W with mem_din[2]=1 clears ovf.
  - 0x08 IN_DATA: R returns the latched word. Write is ignored.
  - 0x0C IN_STATUS: R = {30'b0, ovr, vld}. W clears vld when mem_din[0]=1 and clears ovr when mem_din[1]=1.
  - 0x10 CYCLE: R returns the counter. Any write zeroes it.
  - 0x14 LED: R/W the low LED_W bits; upper bits read 0.
  - Other offsets read 0; writes are ignored.
- Reads have no side effects. The address bus is live on every instruction, not only on loads.
- TX FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the extra wrap bit.
  - Pop occurs when out_valid & out_ready.
  - A push when full is dropped and sets ovf (sticky). full is evaluated from the pre-edge state, so a push is dropped even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full and not empty: both happen; count is unchanged.
  - A push into an empty FIFO raises out_valid on the next cycle (no bypass).
  - out_data = head entry; it is don't-care while out_valid=0.
- Input latch:
  - When in_valid=1: in_data is latched and vld is set. If vld was already 1, ovr is also set.
  - If in_valid and a CPU clear of vld occur in the same cycle, set wins (vld=1).
  - If an ovf clear and a dropped push occur in the same cycle, set wins.
- Cycle counter:
  - 32-bit; increments every cycle and wraps from FFFF_FFFF to 0.
  - A write at edge t makes it 0 after edge t; it then resumes incrementing.
- Reset (rst=0, asynchronous):
  - FIFO emptied; out_valid=0.
  - ovf, vld and ovr cleared; latched word = 0.
  - led = 0; counter = 0.
  - Reset mid-operation discards FIFO contents.
  - Combinational outputs (dm_*, mem_dout) follow their inputs regardless of reset.

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants (OFF_OUT_DATA, OFF_OUT_STATUS, OFF_IN_DATA, OFF_IN_STATUS, OFF_CYCLE, OFF_LED);
  - status bit indices.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push, pop, din, dout, full, empty. Overflow policy lives in mmio_bridge, not in the FIFO.

Test Plan:
- Reset then release; read 0x7F04 and 0x7F10 in the first cycle -> 0x2 (empty) and a small count; out_valid=0; led=0.
- Store 0xDEADBEEF to 0x40 with dm_dout modelled as RAM; load 0x40 -> dm_we=1 and dm_addr=0x10 on the store cycle; mem_dout=0xDEADBEEF on the load.
- With out_ready=0, push values 1..9 to 0x7F00 -> 0x7F04 reads 0x5 (full+ovf); raise out_ready -> out_data sequence 1..8, then out_valid=0 and status 0x6; write 0x4 -> status 0x2.
- Full FIFO, out_ready=1 and a push in the same cycle -> push dropped, ovf=1, count=7 afterwards.
- Pulse in_valid with 0x1234, then 0x5678 -> IN_DATA=0x5678, IN_STATUS=0x3; write 0x3 in the same cycle as a new in_valid -> IN_STATUS=0x1.
- Write 0xFFFFFFFF to LED -> led=0xFFFF and a read returns 0x0000FFFF; write to CYCLE, read it 5 cycles later -> 4 or 5 depending on read timing, deterministic per bench; assert rst mid-sequence -> all state reads back at reset values.
